stopwatch_bcd_counter: RTL and testbench
========================================

# stopwatch_bcd_counter

Stopwatch time base and BCD counter that produces the six display digits (MM:SS.cc) consumed by the digit-scan/anode multiplexer stage. It divides the system clock down to a centisecond tick, counts in packed BCD with per-digit carry, and is controlled by start/stop and clear inputs through a small run-state machine. All outputs are registered. The optional lap feature freezes the displayed value while counting continues.

## Interface
- CLK_HZ, 100_000_000: system clock frequency in Hz.
- TICK_HZ, 100: count rate in Hz (one centisecond); CLK_HZ/TICK_HZ must be an integer ≥ 2.
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset; one clock domain only.
- start_stop  input  1  synchronous, debounced level; each rising edge toggles run/pause.
- clear  input  1  synchronous level; while high, forces counters to zero and state to IDLE.
- lap  input  1  synchronous level; rising edge toggles display freeze (only with LAP_HOLD_EN).
- digit1  output  4  centiseconds ones (0-9).
- digit2  output  4  centiseconds tens (0-9).
- digit3  output  4  seconds ones (0-9).
- digit4  output  4  seconds tens (0-5).
- digit5  output  4  minutes ones (0-9).
- digit6  output  4  minutes tens (0-5).
- running  output  1  high while state is RUN.
- wrap  output  1  one-cycle pulse when count rolls 59:59.99 -> 00:00.00.

## Operation
- Reset values: all digits 0, running 0, wrap 0, state IDLE, prescaler 0, edge registers 0, freeze 0.
- Edge detect: start_stop and lap registered once; rising edge = current & ~registered.
- States: IDLE (zero, stopped), RUN, PAUSE.
  - IDLE --start edge--> RUN, prescaler cleared to 0.
  - RUN --start edge--> PAUSE; prescaler holds.
  - PAUSE --start edge--> RUN; prescaler resumes from held value.
  - any --clear high--> IDLE; clear has priority over a simultaneous start edge.
- Prescaler counts 0..DIV-1 (DIV = CLK_HZ/TICK_HZ) only in RUN; tick is a one-cycle internal strobe when prescaler = DIV-1 in RUN.
- On tick: digit1 increments; each digit wraps to 0 at its max (9 or 5) and carries to the next; carries ripple combinationally within the same cycle.
- Wrap: on tick with count 59:59.99, all digits become 0, wrap pulses that cycle, state remains RUN.
- Digit values are never out of range; no binary intermediate, pure BCD.

## Timing
- start edge sampled at edge n -> running high after edge n.
- First increment occurs DIV cycles after entering RUN from IDLE.
- Digit outputs update on the same edge that the tick is registered; latency tick -> output = 0 extra cycles.
- clear asserted at edge n -> digits 0 and running 0 after edge n; a tick coinciding with clear is discarded.
- reset mid-count: immediate asynchronous return to reset values.

## Configuration
- LAP_HOLD_EN defined: lap rising edge toggles freeze; while frozen, digit1..digit6 hold the value captured at the edge, internal count continues; clear also releases freeze. running and wrap are unaffected by freeze.
- LAP_HOLD_EN undefined: lap input ignored, no capture registers; digit outputs always show the live count.

## Structure
- Package stopwatch_pkg: run-state encoding (IDLE, RUN, PAUSE), digit max constants (9, 5), BCD digit width 4.
- Sub-module bcd_digit_counter: parameter MAX; inputs clk, reset, clear, inc; outputs q[3:0], carry (inc & q==MAX). Six instances chained; top holds prescaler, FSM, edge detect, lap capture.

## Test plan
- CLK_HZ=1000, TICK_HZ=100 (DIV=10): reset, start pulse -> running=1; after 10 cycles digit1=1; after 100 cycles digit2=1, digit1=0.
- Preload-by-run to 00:59.99, one tick -> digit5=1, digits 4..1 = 0.
- Run to 59:59.99, one tick -> all digits 0, wrap high exactly one cycle, running stays 1.
- Start, run 35 cycles, stop -> digits hold 00:00.03 for 100 cycles; restart -> next increment after 5 cycles (prescaler held).
- clear and start_stop rising in the same cycle while RUN -> state IDLE, digits 0, running 0.
- LAP_HOLD_EN: at 00:00.20 pulse lap, run 50 more ticks -> outputs stay 00:00.20; second lap -> outputs show 00:00.70.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch BCD counter: run-state encoding,
// BCD digit width and per-digit maximum values.
package stopwatch_pkg;

    localparam int BCD_W      = 4;
    localparam int NUM_DIGITS = 6;

    localparam logic [BCD_W-1:0] MAX_NINE = 4'd9;
    localparam logic [BCD_W-1:0] MAX_FIVE = 4'd5;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } run_state_e;

    // Digit order is cc ones, cc tens, s ones, s tens, m ones, m tens.
    function automatic bcd_t digit_max(input int idx);
        return (idx == 3 || idx == 5) ? MAX_FIVE : MAX_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit with wrap at MAX; carry is combinational so a chain of these
// ripples a tick through every digit within one cycle.
module bcd_digit_counter
    import stopwatch_pkg::*;
#(
    parameter bcd_t MAX = MAX_NINE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [BCD_W-1:0] q,
    output logic             carry
);

    assign carry = inc && (q == MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (inc) begin
            q <= (q == MAX) ? '0 : q + 4'd1;
        end
    end

endmodule

// File: rtl/stopwatch_bcd_counter.sv
// Stopwatch top: centisecond prescaler, IDLE/RUN/PAUSE run-state machine and six
// chained BCD digits (MM:SS.cc). Optional lap display freeze under `LAP_HOLD_EN.
module stopwatch_bcd_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic [3:0] digit5,
    output logic [3:0] digit6,
    output logic       running,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    run_state_e state, state_nxt;
    logic       ss_q;
    logic       start_edge;
    logic [PW-1:0] presc;
    logic       tick;

    logic [NUM_DIGITS-1:0]            inc;
    logic [NUM_DIGITS-1:0]            carry;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] cnt;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] disp;

    assign start_edge = start_stop && !ss_q;
    assign tick       = (state == ST_RUN) && (presc == PRESC_LAST) && !clear;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ss_q <= 1'b0;
        end else begin
            ss_q <= start_stop;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // clear wins over a start edge arriving in the same cycle
    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_IDLE;
        end else if (start_edge) begin
            case (state)
                ST_IDLE:  state_nxt = ST_RUN;
                ST_RUN:   state_nxt = ST_PAUSE;
                ST_PAUSE: state_nxt = ST_RUN;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // The prescaler only advances in RUN, so a pause resumes mid-interval.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (clear) begin
            presc <= '0;
        end else if (state == ST_IDLE && start_edge) begin
            presc <= '0;
        end else if (state == ST_RUN) begin
            presc <= (presc == PRESC_LAST) ? '0 : presc + 1'b1;
        end
    end

    assign inc = {carry[NUM_DIGITS-2:0], tick};

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit_counter #(
            .MAX (digit_max(i))
        ) u_digit (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .inc   (inc[i]),
            .q     (cnt[i]),
            .carry (carry[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            running <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            running <= (state_nxt == ST_RUN);
            wrap    <= carry[NUM_DIGITS-1];
        end
    end

`ifdef LAP_HOLD_EN
    logic                             lap_q;
    logic                             freeze;
    logic [NUM_DIGITS-1:0][BCD_W-1:0] hold;
    logic                             lap_edge;

    assign lap_edge = lap && !lap_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lap_q  <= 1'b0;
            freeze <= 1'b0;
            hold   <= '0;
        end else begin
            lap_q <= lap;
            if (clear) begin
                freeze <= 1'b0;
            end else if (lap_edge) begin
                freeze <= !freeze;
                if (!freeze) begin
                    hold <= cnt;
                end
            end
        end
    end

    assign disp = freeze ? hold : cnt;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign disp       = cnt;
`endif

    assign digit1 = disp[0];
    assign digit2 = disp[1];
    assign digit3 = disp[2];
    assign digit4 = disp[3];
    assign digit5 = disp[4];
    assign digit6 = disp[5];

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Directed bench for stopwatch_bcd_counter at CLK_HZ=1000, TICK_HZ=100 (ten clocks per tick).
module tb_stopwatch_bcd_counter;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic       lap;
    logic [3:0] digit1, digit2, digit3, digit4, digit5, digit6;
    logic       running;
    logic       wrap;

    int checks = 0;
    int errors = 0;
    logic [23:0] pv;

    stopwatch_bcd_counter #(
        .CLK_HZ  (1000),
        .TICK_HZ (100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
        .lap        (lap),
        .digit1     (digit1),
        .digit2     (digit2),
        .digit3     (digit3),
        .digit4     (digit4),
        .digit5     (digit5),
        .digit6     (digit6),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] shown();
        return {digit6, digit5, digit4, digit3, digit2, digit1};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press();
        start_stop = 1'b1;
        @(negedge clk);
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // Loads the digit registers directly while the counter is idle.
    task preload(input logic [23:0] v);
        pv = v;
        force dut.g_digit[0].u_digit.q = pv[3:0];
        force dut.g_digit[1].u_digit.q = pv[7:4];
        force dut.g_digit[2].u_digit.q = pv[11:8];
        force dut.g_digit[3].u_digit.q = pv[15:12];
        force dut.g_digit[4].u_digit.q = pv[19:16];
        force dut.g_digit[5].u_digit.q = pv[23:20];
        #1;
        release dut.g_digit[0].u_digit.q;
        release dut.g_digit[1].u_digit.q;
        release dut.g_digit[2].u_digit.q;
        release dut.g_digit[3].u_digit.q;
        release dut.g_digit[4].u_digit.q;
        release dut.g_digit[5].u_digit.q;
        @(negedge clk);
    endtask

    task automatic test_reset();
        checks++; if (shown() !== 24'h000000) begin errors++; $display("FAIL reset_digits got %h want 000000", shown()); end
        checks++; if (running !== 1'b0) begin errors++; $display("FAIL reset_running got %b want 0", running); end
        checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
        reset = 1'b0;
        cyc(3);
        checks++; if (shown() !== 24'h000000 || running !== 1'b0) begin errors++; $display("FAIL idle_hold got %h/%b want 000000/0", shown(), running); end
    endtask

    task automatic test_count();
        press();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL start_running got %b want 1", running); end
        cyc(9);
        checks++; if (shown() !== 24'h000000) begin errors++; $display("FAIL pre_first_tick got %h want 000000", shown()); end
        cyc(1);
        checks++; if (shown() !== 24'h000001) begin errors++; $display("FAIL first_tick got %h want 000001", shown()); end
        cyc(89);
        checks++; if (shown() !== 24'h000009) begin errors++; $display("FAIL tick9 got %h want 000009", shown()); end
        cyc(1);
        checks++; if (shown() !== 24'h000010) begin errors++; $display("FAIL tick10_carry got %h want 000010", shown()); end
    endtask

    task automatic test_pause();
        do_clear();
        checks++; if (shown() !== 24'h000000 || running !== 1'b0) begin errors++; $display("FAIL clear got %h/%b want 000000/0", shown(), running); end
        press();
        cyc(34);
        press();
        checks++; if (shown() !== 24'h000003 || running !== 1'b0) begin errors++; $display("FAIL pause got %h/%b want 000003/0", shown(), running); end
        cyc(100);
        checks++; if (shown() !== 24'h000003) begin errors++; $display("FAIL pause_hold got %h want 000003", shown()); end
        press();
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL resume_running got %b want 1", running); end
        cyc(4);
        checks++; if (shown() !== 24'h000003) begin errors++; $display("FAIL resume_early got %h want 000003", shown()); end
        cyc(1);
        checks++; if (shown() !== 24'h000004) begin errors++; $display("FAIL resume_tick got %h want 000004", shown()); end
    endtask

    task automatic test_clear_start();
        cyc(3);
        clear = 1'b1;
        start_stop = 1'b1;
        cyc(1);
        checks++; if (shown() !== 24'h000000 || running !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL clear_vs_start got %h/%b/%b want 000000/0/0", shown(), running, wrap); end
        clear = 1'b0;
        start_stop = 1'b0;
        cyc(20);
        checks++; if (shown() !== 24'h000000 || running !== 1'b0) begin errors++; $display("FAIL clear_stays_idle got %h/%b want 000000/0", shown(), running); end
    endtask

    task automatic test_minute_carry();
        preload(24'h005999);
        checks++; if (shown() !== 24'h005999) begin errors++; $display("FAIL preload_min got %h want 005999", shown()); end
        press();
        cyc(9);
        checks++; if (shown() !== 24'h005999) begin errors++; $display("FAIL pre_min_carry got %h want 005999", shown()); end
        cyc(1);
        checks++; if (shown() !== 24'h010000) begin errors++; $display("FAIL min_carry got %h want 010000", shown()); end
    endtask

    task automatic test_wrap();
        do_clear();
        preload(24'h595999);
        press();
        cyc(9);
        checks++; if (shown() !== 24'h595999 || wrap !== 1'b0) begin errors++; $display("FAIL pre_wrap got %h/%b want 595999/0", shown(), wrap); end
        cyc(1);
        checks++; if (shown() !== 24'h000000) begin errors++; $display("FAIL wrap_digits got %h want 000000", shown()); end
        checks++; if (wrap !== 1'b1 || running !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b/%b want 1/1", wrap, running); end
        cyc(1);
        checks++; if (wrap !== 1'b0 || running !== 1'b1) begin errors++; $display("FAIL wrap_one_cycle got %b/%b want 0/1", wrap, running); end
        cyc(9);
        checks++; if (shown() !== 24'h000001) begin errors++; $display("FAIL after_wrap got %h want 000001", shown()); end
    endtask

    task automatic test_lap();
        logic [23:0] exp_frozen;
`ifdef LAP_HOLD_EN
        exp_frozen = 24'h000020;
`else
        exp_frozen = 24'h000069;
`endif
        do_clear();
        press();
        cyc(200);
        checks++; if (shown() !== 24'h000020) begin errors++; $display("FAIL lap_pre got %h want 000020", shown()); end
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        checks++; if (shown() !== 24'h000020) begin errors++; $display("FAIL lap_capture got %h want 000020", shown()); end
        cyc(498);
        checks++; if (shown() !== exp_frozen) begin errors++; $display("FAIL lap_hold got %h want %h", shown(), exp_frozen); end
        checks++; if (running !== 1'b1) begin errors++; $display("FAIL lap_running got %b want 1", running); end
        lap = 1'b1;
        cyc(1);
        lap = 1'b0;
        checks++; if (shown() !== 24'h000070) begin errors++; $display("FAIL lap_release got %h want 000070", shown()); end
        cyc(10);
        checks++; if (shown() !== 24'h000071) begin errors++; $display("FAIL lap_live got %h want 000071", shown()); end
    endtask

    task automatic test_reset_mid();
        #2;
        reset = 1'b1;
        #1;
        checks++; if (shown() !== 24'h000000 || running !== 1'b0 || wrap !== 1'b0) begin errors++; $display("FAIL async_reset got %h/%b/%b want 000000/0/0", shown(), running, wrap); end
        @(negedge clk);
        reset = 1'b0;
        cyc(15);
        checks++; if (shown() !== 24'h000000 || running !== 1'b0) begin errors++; $display("FAIL post_reset_idle got %h/%b want 000000/0", shown(), running); end
    endtask

    initial begin
        reset      = 1'b1;
        start_stop = 1'b0;
        clear      = 1'b0;
        lap        = 1'b0;
        pv         = '0;
        cyc(2);
        test_reset();
        test_count();
        test_pause();
        test_clear_start();
        test_minute_carry();
        test_wrap();
        test_lap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
